oam_dma_arbiter: RTL and testbench

OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

---
 rtl/oam_dma_arbiter_pkg.sv | 28 ++
 rtl/oam_dma_arbiter_dma_addr_gen.sv | 45 ++++
 rtl/oam_dma_arbiter.sv | 176 +++++++++++++++++
 tb/tb_oam_dma_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// oam_dma_arbiter_pkg
// Shared types and constants for the OAM DMA arbiter and its address
// generator: the DMA FSM state enum, the fixed bus addresses and the
// echo-RAM page wrap helper.
// -----------------------------------------------------------------------------
package oam_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [7:0]  HI_PAGE      = 8'hFF;

  // Pages E0-FF alias work RAM at C0-DF, so the source is pulled back by 0x20.
  localparam logic [7:0]  ECHO_FIRST   = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET  = 8'h20;

  function automatic logic [7:0] echo_wrap(input logic [7:0] page);
    return (page >= ECHO_FIRST) ? (page - ECHO_OFFSET) : page;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter_dma_addr_gen.sv
// -----------------------------------------------------------------------------
// dma_addr_gen
// Forms the main-memory address and strobes the DMA engine drives on each
// transfer step.
// Ports:
//   page_i     source page register
//   index_i    current byte index within the transfer
//   state_i    current DMA FSM state
//   dma_addr_o {effective page, index} in READ, OAM_BASE + index in WRITE
//   dma_rd_o   high in READ
//   dma_wr_o   high in WRITE
// -----------------------------------------------------------------------------
module dma_addr_gen
  import oam_dma_arbiter_pkg::*;
(
  input  logic [7:0]  page_i,
  input  logic [7:0]  index_i,
  input  dma_state_e  state_i,
  output logic [15:0] dma_addr_o,
  output logic        dma_rd_o,
  output logic        dma_wr_o
);

  logic [7:0] eff_page;

  assign eff_page = echo_wrap(page_i);

  always_comb begin
    dma_addr_o = 16'h0000;
    dma_rd_o   = 1'b0;
    dma_wr_o   = 1'b0;
    case (state_i)
      ST_READ: begin
        dma_addr_o = {eff_page, index_i};
        dma_rd_o   = 1'b1;
      end
      ST_WRITE: begin
        dma_addr_o = OAM_BASE + {8'h00, index_i};
        dma_wr_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// -----------------------------------------------------------------------------
// oam_dma_arbiter
// OAM DMA engine plus CPU bus arbiter. A CPU write to FF46 latches a source
// page and copies DMA_LEN bytes from {page, 00..} into OAM at FE00. While the
// engine owns the main bus (READ/WRITE) CPU accesses below FF00 are blocked
// (reads return FF, writes dropped); the FF00-FFFF high page is always routed
// straight to the Hi port.
// Ports:
//   i_Clk, i_Rst_n (async active-low), i_Enable (clock enable)
//   i_Cpu_*  CPU address / write data / write strobe / read strobe
//   o_Cpu_Bus  CPU read data (00 when no read strobe)
//   o_Mem_*, i_Mem_Bus  main memory port
//   o_Hi_*,  i_Hi_Bus   high-page port (FF00-FFFF)
//   o_Dma_Active        high while in START, READ or WRITE
// Configuration:
//   OAM_DMA_READBACK_EN  when defined, CPU reads of FF46 return the page
//                        register; otherwise they return FF.
// -----------------------------------------------------------------------------
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter int DMA_LEN = 160
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Enable,
  input  logic [15:0] i_Cpu_Address,
  input  logic [7:0]  i_Cpu_Bus,
  input  logic        i_Cpu_Bus_Out,
  input  logic        i_Cpu_Bus_In,
  output logic [7:0]  o_Cpu_Bus,
  output logic [15:0] o_Mem_Address,
  output logic [7:0]  o_Mem_Bus,
  output logic        o_Mem_Write,
  output logic        o_Mem_Read,
  input  logic [7:0]  i_Mem_Bus,
  output logic [7:0]  o_Hi_Address,
  output logic [7:0]  o_Hi_Bus,
  output logic        o_Hi_Write,
  output logic        o_Hi_Read,
  input  logic [7:0]  i_Hi_Bus,
  output logic        o_Dma_Active
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_e state_q, state_d;
  logic [7:0] page_q,  page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] data_q,  data_d;
  logic       active_q, active_d;

  logic        is_dma_reg;
  logic        dma_reg_wr;
  logic        hi_sel;
  logic        lo_sel;
  logic        dma_busy;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic        dma_wr;
  logic [7:0]  dma_reg_rdata;

  assign is_dma_reg = (i_Cpu_Address == DMA_REG_ADDR);
  assign dma_reg_wr = i_Cpu_Bus_Out && is_dma_reg;
  assign hi_sel     = (i_Cpu_Address[15:8] == HI_PAGE) && !is_dma_reg;
  assign lo_sel     = (i_Cpu_Address[15:8] != HI_PAGE);
  assign dma_busy   = (state_q == ST_READ) || (state_q == ST_WRITE);

`ifdef OAM_DMA_READBACK_EN
  assign dma_reg_rdata = page_q;
`else
  assign dma_reg_rdata = 8'hFF;
`endif

  dma_addr_gen u_addr_gen (
    .page_i     (page_q),
    .index_i    (index_q),
    .state_i    (state_q),
    .dma_addr_o (dma_addr),
    .dma_rd_o   (dma_rd),
    .dma_wr_o   (dma_wr)
  );

  // Next-state: an FF46 write wins over whatever the engine was doing, so a
  // rewrite mid-transfer restarts cleanly from index 0.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    index_d  = index_q;
    data_d   = data_q;
    active_d = active_q;
    if (i_Enable) begin
      if (dma_reg_wr) begin
        page_d  = i_Cpu_Bus;
        index_d = 8'h00;
        state_d = ST_START;
      end else begin
        case (state_q)
          ST_START: state_d = ST_READ;
          ST_READ: begin
            data_d  = i_Mem_Bus;
            state_d = ST_WRITE;
          end
          ST_WRITE: begin
            index_d = index_q + 8'd1;
            state_d = (index_q < LAST_IDX) ? ST_READ : ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      active_d = (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= ST_IDLE;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      data_q   <= 8'h00;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      index_q  <= index_d;
      data_q   <= data_d;
      active_q <= active_d;
    end
  end

  assign o_Dma_Active = active_q;

  // Main port: engine owns it in READ/WRITE, otherwise low-page CPU traffic
  // passes through.
  always_comb begin
    o_Mem_Address = 16'h0000;
    o_Mem_Bus     = 8'h00;
    o_Mem_Write   = 1'b0;
    o_Mem_Read    = 1'b0;
    if (dma_busy) begin
      o_Mem_Address = dma_addr;
      o_Mem_Read    = dma_rd;
      o_Mem_Write   = dma_wr;
      o_Mem_Bus     = dma_wr ? data_q : 8'h00;
    end else if (lo_sel) begin
      o_Mem_Address = i_Cpu_Address;
      o_Mem_Bus     = i_Cpu_Bus;
      o_Mem_Write   = i_Cpu_Bus_Out;
      o_Mem_Read    = i_Cpu_Bus_In;
    end
  end

  always_comb begin
    o_Hi_Address = 8'h00;
    o_Hi_Bus     = 8'h00;
    o_Hi_Write   = 1'b0;
    o_Hi_Read    = 1'b0;
    if (hi_sel) begin
      o_Hi_Address = i_Cpu_Address[7:0];
      o_Hi_Bus     = i_Cpu_Bus;
      o_Hi_Write   = i_Cpu_Bus_Out;
      o_Hi_Read    = i_Cpu_Bus_In;
    end
  end

  always_comb begin
    o_Cpu_Bus = 8'h00;
    if (i_Cpu_Bus_In) begin
      if (is_dma_reg)    o_Cpu_Bus = dma_reg_rdata;
      else if (hi_sel)   o_Cpu_Bus = i_Hi_Bus;
      else if (dma_busy) o_Cpu_Bus = 8'hFF;
      else               o_Cpu_Bus = i_Mem_Bus;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// -----------------------------------------------------------------------------
// tb_oam_dma_arbiter
// Scoreboarded bench: each FF46 write pushes the full list of expected main
// bus transactions (read source byte, write it to OAM) computed from the page
// and a memory content function; a negedge monitor pops one entry for every
// enabled cycle in which the main port shows a strobe.
// -----------------------------------------------------------------------------
module tb_oam_dma_arbiter;

  localparam int DMA_LEN = 160;
  localparam int XFER    = 1 + 2 * DMA_LEN;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic [7:0]  hi_addr;
  logic [7:0]  hi_wdata;
  logic        hi_wr;
  logic        hi_rd;
  logic [7:0]  hi_rdata;
  logic        dma_active;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] seed;
  logic [7:0] hi_data;
  logic [7:0] cur_page;
  bit         cpu_probe;

  always #5 clk = ~clk;

  oam_dma_arbiter #(.DMA_LEN(DMA_LEN)) dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_Enable      (en),
    .i_Cpu_Address (cpu_addr),
    .i_Cpu_Bus     (cpu_wdata),
    .i_Cpu_Bus_Out (cpu_wr),
    .i_Cpu_Bus_In  (cpu_rd),
    .o_Cpu_Bus     (cpu_rdata),
    .o_Mem_Address (mem_addr),
    .o_Mem_Bus     (mem_wdata),
    .o_Mem_Write   (mem_wr),
    .o_Mem_Read    (mem_rd),
    .i_Mem_Bus     (mem_rdata),
    .o_Hi_Address  (hi_addr),
    .o_Hi_Bus      (hi_wdata),
    .o_Hi_Write    (hi_wr),
    .o_Hi_Read     (hi_rd),
    .i_Hi_Bus      (hi_rdata),
    .o_Dma_Active  (dma_active)
  );

  function automatic logic [7:0] mem_fn(input logic [15:0] a, input logic [7:0] s);
    logic [7:0] m;
    m = a[7:0] * 8'd7;
    return m ^ a[15:8] ^ s;
  endfunction

  assign mem_rdata = mem_fn(mem_addr, seed);
  assign hi_rdata  = hi_data;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  // Monitor: one scoreboard entry per enabled cycle with a main-port strobe.
  always @(negedge clk) begin : mon
    txn_t e;
    if (rst_n && en && !cpu_probe && (mem_rd || mem_wr)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mem got wr=%0b rd=%0b addr=%h required no access",
                 mem_wr, mem_rd, mem_addr);
      end else begin
        e = exp_q.pop_front();
        if (mem_wr !== e.wr || mem_rd !== !e.wr || mem_addr !== e.addr ||
            (e.wr && mem_wdata !== e.data)) begin
          errors++;
          $display("FAIL dma_txn got wr=%0b rd=%0b addr=%h data=%h required wr=%0b addr=%h data=%h",
                   mem_wr, mem_rd, mem_addr, mem_wdata, e.wr, e.addr, e.data);
        end
      end
    end
  end

  task automatic idle_inputs();
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_wr    = 1'b0;
    cpu_rd    = 1'b0;
  endtask

  // Reference: byte k is read from {page', k} and written to FE00+k, where
  // page' folds E0-FF back by 0x20.
  task automatic push_model(input logic [7:0] page);
    logic [7:0] eff;
    eff = (page >= 8'hE0) ? (page - 8'h20) : page;
    exp_q.delete();
    for (int k = 0; k < DMA_LEN; k++) begin
      logic [15:0] src;
      src = {eff, 8'(k)};
      exp_q.push_back('{wr: 1'b0, addr: src, data: 8'h00});
      exp_q.push_back('{wr: 1'b1, addr: 16'hFE00 + 16'(k), data: mem_fn(src, seed)});
    end
  endtask

  // Entered and left at posedge+1.
  task automatic start_dma(input logic [7:0] page);
    en        = 1'b1;
    cpu_addr  = 16'hFF46;
    cpu_wdata = page;
    cpu_wr    = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    cur_page = page;
    push_model(page);
  endtask

  task automatic step_en(inout int all_c, inout int en_c);
    @(posedge clk);
    all_c++;
    if (en) en_c++;
    #1;
  endtask

  // mode 0: always enabled, 1: random enable, 2: 5-cycle freeze, 3: CPU probes
  task automatic run_to_idle(input int mode, output int en_c, output int all_c);
    logic [15:0] f_addr;
    logic        f_rd, f_wr;
    bit          done;
    logic [7:0]  rb_exp;
    en_c = 0; all_c = 0; done = 0;
    while (dma_active && all_c < 4000) begin
      en = 1'b1;
      if (mode == 1) en = ($urandom_range(3) != 0);
      if (mode == 2 && en_c == 100 && !done) begin
        done = 1; f_addr = mem_addr; f_rd = mem_rd; f_wr = mem_wr; en = 1'b0;
        repeat (5) begin
          step_en(all_c, en_c);
          check("freeze_addr", 32'(mem_addr), 32'(f_addr));
          check("freeze_strobes", 32'({mem_rd, mem_wr}), 32'({f_rd, f_wr}));
          check("freeze_active", 32'(dma_active), 32'd1);
        end
        en = 1'b1;
      end
      if (mode == 3 && en_c == 40 && !done) begin
        done = 1;
        cpu_addr = 16'h8000; cpu_rd = 1'b1; #1;
        check("blocked_read_data", 32'(cpu_rdata), 32'hFF);
        step_en(all_c, en_c);
        check("blocked_read_data2", 32'(cpu_rdata), 32'hFF);
        cpu_addr = 16'hFF80; #1;
        check("hi_read_strobe", 32'({hi_rd, hi_wr}), 32'b10);
        check("hi_read_addr", 32'(hi_addr), 32'h80);
        check("hi_read_data", 32'(cpu_rdata), 32'(hi_data));
        step_en(all_c, en_c);
        cpu_rd = 1'b0; cpu_addr = 16'h8000; cpu_wdata = 8'h5A; cpu_wr = 1'b1;
        step_en(all_c, en_c);
        step_en(all_c, en_c);
        cpu_addr = 16'hFF10; cpu_wdata = 8'h3C; #1;
        check("hi_write", 32'({hi_wr, hi_addr, hi_wdata}), 32'({1'b1, 8'h10, 8'h3C}));
        step_en(all_c, en_c);
        cpu_wr = 1'b0; cpu_addr = 16'hFF46; cpu_rd = 1'b1; #1;
`ifdef OAM_DMA_READBACK_EN
        rb_exp = cur_page;
`else
        rb_exp = 8'hFF;
`endif
        check("ff46_read", 32'(cpu_rdata), 32'(rb_exp));
        step_en(all_c, en_c);
        idle_inputs();
      end
      step_en(all_c, en_c);
    end
    en = 1'b1;
    if (all_c >= 4000) begin
      errors++;
      $display("FAIL idle_timeout got=%0d cycles required=done", all_c);
    end
  endtask

  task automatic wait_write(input logic [15:0] a);
    int n;
    n = 0;
    while (!(mem_wr && mem_addr == a) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check("reach_index", 32'(mem_wr && mem_addr == a), 32'd1);
  endtask

  int ec, ac;

  initial begin
    rst_n = 1'b0; en = 1'b0; cpu_probe = 0; cur_page = 8'h00;
    idle_inputs();
    seed = 8'($urandom); hi_data = 8'($urandom);
    repeat (3) @(posedge clk); #1;
    check("rst_active", 32'(dma_active), 32'd0);
    check("rst_mem_strobes", 32'({mem_rd, mem_wr}), 32'd0);
    check("rst_hi_strobes", 32'({hi_rd, hi_wr}), 32'd0);
    check("rst_cpu_bus", 32'(cpu_rdata), 32'd0);
    rst_n = 1'b1; en = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("post_rst_active", 32'(dma_active), 32'd0);

    // Idle pass-through of low-page CPU traffic.
    cpu_probe = 1;
    cpu_addr = 16'h1234; cpu_rd = 1'b1; #1;
    check("idle_read", 32'({mem_rd, mem_wr, mem_addr}), 32'({2'b10, 16'h1234}));
    check("idle_read_data", 32'(cpu_rdata), 32'(mem_fn(16'h1234, seed)));
    cpu_rd = 1'b0; cpu_addr = 16'h4321; cpu_wdata = 8'hA5; cpu_wr = 1'b1; #1;
    check("idle_write", 32'({mem_wr, mem_addr, mem_wdata}), 32'({1'b1, 16'h4321, 8'hA5}));
    check("no_read_bus_zero", 32'(cpu_rdata), 32'd0);
    idle_inputs(); #1;
    cpu_probe = 0;
    @(posedge clk); #1;

    start_dma(8'hC0); run_to_idle(0, ec, ac);
    check("c0_cycles", 32'(ec), 32'(XFER));
    check("c0_drained", 32'(exp_q.size()), 32'd0);

    start_dma(8'hE1); run_to_idle(0, ec, ac);
    check("e1_cycles", 32'(ec), 32'(XFER));
    check("e1_drained", 32'(exp_q.size()), 32'd0);

    start_dma(8'($urandom_range(8'hDF))); run_to_idle(3, ec, ac);
    check("probe_cycles", 32'(ec), 32'(XFER));

    start_dma(8'h47); run_to_idle(2, ec, ac);
    check("freeze_en_cycles", 32'(ec), 32'(XFER));
    check("freeze_all_cycles", 32'(ac), 32'(XFER + 5));

    for (int i = 0; i < 4; i++) begin
      seed = 8'($urandom);
      start_dma(8'($urandom)); run_to_idle(1, ec, ac);
      check("rand_cycles", 32'(ec), 32'(XFER));
      check("rand_drained", 32'(exp_q.size()), 32'd0);
    end

    // Restart mid-transfer.
    start_dma(8'h3A); wait_write(16'hFE32);
    start_dma(8'h80); run_to_idle(0, ec, ac);
    check("restart_cycles", 32'(ec), 32'(XFER));
    check("restart_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-transfer.
    start_dma(8'h55); wait_write(16'hFE0A);
    rst_n = 1'b0; exp_q.delete(); #1;
    check("midrst_active", 32'(dma_active), 32'd0);
    check("midrst_strobes", 32'({mem_rd, mem_wr}), 32'd0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk); #1;
    check("midrst_stays_idle", 32'(dma_active), 32'd0);

    seed = 8'($urandom);
    start_dma(8'hFF); run_to_idle(0, ec, ac);
    check("after_rst_cycles", 32'(ec), 32'(XFER));
    check("after_rst_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
